// File: rtl/ams_gen2.sv
`default_nettype none
// ============================================================================
// Module   : ams_gen2
// Purpose  : PWM-DAC config registers, XADC conversion triggering and a DRP
//            readout engine with per-channel results and a sample FIFO.
// Revision : 1.0
// ============================================================================
module ams_gen2 #(
    parameter int N_PWM   = 4,
    parameter int PWM_W   = 24,
    parameter int TRIG_W  = 16,
    parameter int FIFO_AW = 6,
    parameter int DRP_TO  = 255
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    output logic [N_PWM*PWM_W-1:0] dac_o,
    input  logic [TRIG_W-1:0]      dsp_trig_i,
    output logic                   xadc_convst_o,
    input  logic                   xadc_eoc_i,
    input  logic [4:0]             xadc_channel_i,
    output logic                   xadc_den_o,
    output logic [6:0]             xadc_daddr_o,
    input  logic                   xadc_drdy_i,
    input  logic [15:0]            xadc_do_i,
    input  logic [31:0]            sys_addr,
    input  logic [31:0]            sys_wdata,
    input  logic [3:0]             sys_sel,
    input  logic                   sys_wen,
    input  logic                   sys_ren,
    output logic [31:0]            sys_rdata,
    output logic                   sys_err,
    output logic                   sys_ack
);

    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_CNT_W = FIFO_AW + 1;
    localparam int c_TO_W  = (DRP_TO > 1) ? $clog2(DRP_TO) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(DRP_TO - 1);

    localparam logic [19:0] c_A_TRIG  = 20'h00050;
    localparam logic [19:0] c_A_ADIV  = 20'h00054;
    localparam logic [19:0] c_A_CTRL  = 20'h00058;
    localparam logic [19:0] c_A_FCH   = 20'h0005C;
    localparam logic [19:0] c_A_FDATA = 20'h00060;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    logic [PWM_W-1:0]    dac_q [N_PWM];
    logic [TRIG_W:0]     trig_src_q;
    logic [15:0]         auto_div_q;
    logic [15:0]         auto_cnt_q;
    logic [4:0]          fifo_ch_q;
    logic [TRIG_W-1:0]   trig_prev_q;
    logic                convst_q;
    logic                ovr_q, tmo_q, ofl_q;
    logic [11:0]         results_q [32];
    logic [16:0]         fifo_mem_q [c_DEPTH];
    logic [FIFO_AW-1:0]  wptr_q, rptr_q;
    logic [c_CNT_W-1:0]  count_q;
    logic                ack_q;
    logic [31:0]         rdata_q;

    state_e              state_q, state_d;
    logic [4:0]          ch_q, ch_d;
    logic [c_TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic                den_q, den_d;
    logic [6:0]          daddr_q, daddr_d;

    logic [19:0] w_addr;
    logic        w_dac_hit, w_res_hit, w_ctrl_wr, w_clr, w_flush, w_sw_trig;
    logic        w_auto_en, w_auto_tick, w_dsp_fire;
    logic        w_res_we, w_ovr_set, w_tmo_set;
    logic        w_empty, w_full, w_fifo_rd, w_push_req, w_push, w_pop, w_ofl_set;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_addr    = sys_addr[19:0];
    assign w_dac_hit = (w_addr[19:5] == '0) && (w_addr[1:0] == 2'b00)
                       && ({29'd0, w_addr[4:2]} < 32'(N_PWM));
    assign w_res_hit = (w_addr[19:7] == 13'h002) && (w_addr[1:0] == 2'b00);
    assign w_ctrl_wr = sys_wen && (w_addr == c_A_CTRL);
    assign w_sw_trig = w_ctrl_wr && sys_wdata[0];
    assign w_clr     = w_ctrl_wr && sys_wdata[1];
    assign w_flush   = w_ctrl_wr && sys_wdata[2];
    assign w_unused  = ^{sys_sel, sys_addr, sys_wdata, xadc_do_i[3:0]};

    // ---------------- configuration registers ----------------
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N_PWM; i++) dac_q[i] <= '0;
        end else if (sys_wen && w_dac_hit) begin
            for (int i = 0; i < N_PWM; i++) begin
                if (w_addr[4:2] == 3'(i)) dac_q[i] <= sys_wdata[PWM_W-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < N_PWM; gi++) begin : g_dac
        assign dac_o[gi*PWM_W +: PWM_W] = dac_q[gi];
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            trig_src_q <= {1'b1, {TRIG_W{1'b0}}};
            auto_div_q <= '0;
            fifo_ch_q  <= '0;
        end else if (sys_wen) begin
            if (w_addr == c_A_TRIG) trig_src_q <= sys_wdata[TRIG_W:0];
            if (w_addr == c_A_ADIV) auto_div_q <= sys_wdata[15:0];
            if (w_addr == c_A_FCH)  fifo_ch_q  <= sys_wdata[4:0];
        end
    end

    // ---------------- conversion triggers ----------------
    // The >= compare lets a shrinking AUTO_DIV take effect on the next cycle.
    assign w_auto_en   = trig_src_q[TRIG_W];
    assign w_auto_tick = w_auto_en && (auto_cnt_q >= auto_div_q);
    assign w_dsp_fire  = |(dsp_trig_i & ~trig_prev_q & trig_src_q[TRIG_W-1:0]);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            trig_prev_q <= '0;
            auto_cnt_q  <= '0;
            convst_q    <= 1'b0;
        end else begin
            trig_prev_q <= dsp_trig_i;
            auto_cnt_q  <= (!w_auto_en || w_auto_tick) ? 16'd0 : auto_cnt_q + 16'd1;
            convst_q    <= w_auto_tick || w_dsp_fire || w_sw_trig;
        end
    end

    // ---------------- DRP readout FSM ----------------
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            to_cnt_q <= '0;
            den_q    <= 1'b0;
            daddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            to_cnt_q <= to_cnt_d;
            den_q    <= den_d;
            daddr_q  <= daddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        to_cnt_d  = to_cnt_q;
        den_d     = 1'b0;
        daddr_d   = daddr_q;
        w_res_we  = 1'b0;
        w_ovr_set = 1'b0;
        w_tmo_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xadc_eoc_i) begin
                    den_d    = 1'b1;
                    daddr_d  = {2'b00, xadc_channel_i};
                    ch_d     = xadc_channel_i;
                    to_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                w_ovr_set = xadc_eoc_i;
                if (xadc_drdy_i) begin
                    w_res_we = 1'b1;
                    state_d  = S_IDLE;
                end else if (to_cnt_q == c_TO_LAST) begin
                    w_tmo_set = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < 32; c++) results_q[c] <= '0;
        end else if (w_res_we) begin
            results_q[ch_q] <= xadc_do_i[15:4];
        end
    end

    // ---------------- sample FIFO ----------------
    // A pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == c_CNT_W'(c_DEPTH));
    assign w_fifo_rd  = sys_ren && (w_addr == c_A_FDATA);
    assign w_push_req = w_res_we && (ch_q == fifo_ch_q);
    assign w_pop      = w_fifo_rd && !w_empty && !w_flush;
    assign w_push     = w_push_req && !w_flush && (!w_full || w_pop);
    assign w_ofl_set  = w_push_req && !w_flush && w_full && !w_pop;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (w_flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) fifo_mem_q[wptr_q] <= {ch_q, xadc_do_i[15:4]};
    end

    // Sticky flags: a set event in the same cycle as a clear wins.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ovr_q <= 1'b0;
            tmo_q <= 1'b0;
            ofl_q <= 1'b0;
        end else begin
            ovr_q <= w_ovr_set || (ovr_q && !w_clr);
            tmo_q <= w_tmo_set || (tmo_q && !w_clr);
            ofl_q <= w_ofl_set || (ofl_q && !w_clr);
        end
    end

    // ---------------- bus read path ----------------
    always_comb begin
        w_rdata = '0;
        if (w_dac_hit) begin
            for (int i = 0; i < N_PWM; i++) begin
                if (w_addr[4:2] == 3'(i)) w_rdata = 32'(dac_q[i]);
            end
        end else if (w_res_hit) begin
            w_rdata = {20'd0, results_q[w_addr[6:2]]};
        end else if (w_addr == c_A_TRIG) begin
            w_rdata = 32'(trig_src_q);
        end else if (w_addr == c_A_ADIV) begin
            w_rdata = {16'd0, auto_div_q};
        end else if (w_addr == c_A_CTRL) begin
            w_rdata = {16'(count_q), 11'd0, w_full, w_empty, ofl_q, tmo_q, ovr_q};
        end else if (w_addr == c_A_FCH) begin
            w_rdata = {27'd0, fifo_ch_q};
        end else if (w_addr == c_A_FDATA) begin
            w_rdata = w_empty ? 32'h8000_0000
                              : {11'd0, fifo_mem_q[rptr_q][16:12], 4'd0, fifo_mem_q[rptr_q][11:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= sys_wen || sys_ren;
            if (sys_ren) rdata_q <= w_rdata;
        end
    end

    assign xadc_convst_o = convst_q;
    assign xadc_den_o    = den_q;
    assign xadc_daddr_o  = daddr_q;
    assign sys_rdata     = rdata_q;
    assign sys_ack       = ack_q;
    assign sys_err       = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ams_gen2.sv
`default_nettype none
// ============================================================================
// Module   : tb_ams_gen2
// Purpose  : Self-checking bench for ams_gen2 (register table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_ams_gen2;

    localparam int N_PWM   = 4;
    localparam int PWM_W   = 24;
    localparam int TRIG_W  = 16;
    localparam int FIFO_AW = 6;
    localparam int DRP_TO  = 255;
    localparam int DEPTH   = 1 << FIFO_AW;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [N_PWM*PWM_W-1:0] dac_o;
    logic [TRIG_W-1:0]      dsp_trig_i;
    logic                   xadc_convst_o, xadc_eoc_i, xadc_den_o, xadc_drdy_i;
    logic [4:0]             xadc_channel_i;
    logic [6:0]             xadc_daddr_o;
    logic [15:0]            xadc_do_i;
    logic [31:0]            sys_addr, sys_wdata, sys_rdata;
    logic [3:0]             sys_sel;
    logic                   sys_wen, sys_ren, sys_err, sys_ack;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  fifo_ch_m;

    always #5 clk = ~clk;

    ams_gen2 #(.N_PWM(N_PWM), .PWM_W(PWM_W), .TRIG_W(TRIG_W), .FIFO_AW(FIFO_AW), .DRP_TO(DRP_TO)) dut (
        .clk_i(clk), .rstn_i(rstn), .dac_o(dac_o), .dsp_trig_i(dsp_trig_i),
        .xadc_convst_o(xadc_convst_o), .xadc_eoc_i(xadc_eoc_i), .xadc_channel_i(xadc_channel_i),
        .xadc_den_o(xadc_den_o), .xadc_daddr_o(xadc_daddr_o), .xadc_drdy_i(xadc_drdy_i),
        .xadc_do_i(xadc_do_i), .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
        .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata), .sys_err(sys_err),
        .sys_ack(sys_ack)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        sys_addr  = a;
        sys_wdata = d;
        sys_wen   = 1'b1;
        tick();
        sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        sys_addr = a;
        sys_ren  = 1'b1;
        tick();
        sys_ren  = 1'b0;
        d        = sys_rdata;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, e);
    endtask

    // One complete eoc -> den -> drdy transaction; scoreboard tracks FIFO pushes.
    task automatic conv(input logic [4:0] ch, input logic [15:0] data);
        xadc_eoc_i     = 1'b1;
        xadc_channel_i = ch;
        tick();
        check("conv_den", xadc_den_o, 1'b1);
        xadc_eoc_i = 1'b0;
        tick();
        tick();
        xadc_drdy_i = 1'b1;
        xadc_do_i   = data;
        tick();
        xadc_drdy_i = 1'b0;
        if (ch == fifo_ch_m && exp_q.size() < DEPTH)
            exp_q.push_back({11'd0, ch, 4'd0, data[15:4]});
    endtask

    task automatic fifo_read_check(input string name);
        logic [31:0] d, e;
        bus_read(32'h060, d);
        if (exp_q.size() == 0) e = 32'h8000_0000;
        else                   e = exp_q.pop_front();
        check(name, d, e);
    endtask

    task automatic count_pulses(input int ncyc, output int pulses, output int gap_bad, input int gap);
        int last;
        pulses  = 0;
        gap_bad = 0;
        last    = -1;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (xadc_convst_o) begin
                if (last >= 0 && (c - last) != gap) gap_bad++;
                last = c;
                pulses++;
            end
        end
    endtask

    initial begin
        int          p, gb;
        logic [31:0] d;
        logic [15:0] smp;

        vecs[0] = '{32'h000, 32'hFFFF_FFFF, 1'b1, 32'h00FF_FFFF};
        vecs[1] = '{32'h004, 32'h00AB_CDEF, 1'b1, 32'h00AB_CDEF};
        vecs[2] = '{32'h00C, 32'h1234_5678, 1'b1, 32'h0034_5678};
        vecs[3] = '{32'h010, 32'h0000_0055, 1'b1, 32'h0000_0000};
        vecs[4] = '{32'h050, 32'hFFFF_FFFF, 1'b1, 32'h0001_FFFF};
        vecs[5] = '{32'h054, 32'hFFFF_1234, 1'b1, 32'h0000_1234};
        vecs[6] = '{32'h05C, 32'hFFFF_FFF3, 1'b1, 32'h0000_0013};
        vecs[7] = '{32'h200, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
        vecs[8] = '{32'h100, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[9] = '{32'h008, 32'h0000_0000, 1'b0, 32'h0000_0000};

        rstn = 1'b0;
        dsp_trig_i = '0; xadc_eoc_i = 1'b0; xadc_channel_i = '0; xadc_drdy_i = 1'b0;
        xadc_do_i = '0; sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF;
        sys_wen = 1'b0; sys_ren = 1'b0;
        fifo_ch_m = '0;
        repeat (3) tick();
        check("rst_convst", xadc_convst_o, 1'b0);
        check("rst_den", xadc_den_o, 1'b0);
        rstn = 1'b1;
        tick();
        check("rst_dac", dac_o, '0);
        check("rst_daddr", xadc_daddr_o, 7'd0);
        check("rst_err", sys_err, 1'b0);
        check("rst_ack", sys_ack, 1'b0);
        check("rst_rdata", sys_rdata, 32'd0);
        read_check("rst_trig_src", 32'h050, 32'h0001_0000);
        read_check("rst_auto_div", 32'h054, 32'h0);
        read_check("rst_status", 32'h058, 32'h0000_0008);
        read_check("rst_fifo_data", 32'h060, 32'h8000_0000);

        // Register table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, d);
            check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
            check($sformatf("reg_ack%0d", i), sys_ack, 1'b1);
        end
        check("dac_bus", dac_o, {24'h345678, 24'h000000, 24'hABCDEF, 24'hFFFFFF});
        fifo_ch_m = 5'h13;

        // Auto trigger: disabled -> silent, then period AUTO_DIV+1
        bus_write(32'h050, 32'h0);
        tick(); tick();
        count_pulses(8, p, gb, 4);
        check("auto_off_pulses", p, 0);
        bus_write(32'h054, 32'd3);
        bus_write(32'h050, 32'h0001_0000);
        count_pulses(40, p, gb, 4);
        check("auto_pulses", p, 10);
        check("auto_gap", gb, 0);

        // DSP edge trigger
        bus_write(32'h050, 32'h0000_0004);
        repeat (3) tick();
        dsp_trig_i = 16'h0004;
        tick();
        check("dsp_edge_pulse", xadc_convst_o, 1'b1);
        count_pulses(10, p, gb, 1);
        check("dsp_level_no_repeat", p, 0);
        dsp_trig_i = 16'h0008;
        count_pulses(6, p, gb, 1);
        check("dsp_masked", p, 0);
        dsp_trig_i = 16'h0000;
        tick();

        // Software trigger
        bus_write(32'h058, 32'h1);
        check("sw_trig_hi", xadc_convst_o, 1'b1);
        tick();
        check("sw_trig_lo", xadc_convst_o, 1'b0);

        // DRP read of channel 16 (not the FIFO channel)
        xadc_eoc_i = 1'b1; xadc_channel_i = 5'd16;
        tick();
        check("drp_den", xadc_den_o, 1'b1);
        check("drp_daddr", xadc_daddr_o, 7'h10);
        xadc_eoc_i = 1'b0;
        tick();
        check("drp_den_1cyc", xadc_den_o, 1'b0);
        repeat (3) tick();
        xadc_drdy_i = 1'b1; xadc_do_i = 16'hABC0;
        tick();
        xadc_drdy_i = 1'b0;
        read_check("res_ch16", 32'h140, 32'h0000_0ABC);
        read_check("no_push_other_ch", 32'h058, 32'h0000_0008);
        conv(5'd3, 16'h1235);
        read_check("res_ch3", 32'h10C, 32'h0000_0123);

        // Overrun
        xadc_eoc_i = 1'b1; xadc_channel_i = 5'd1;
        tick();
        tick();
        xadc_eoc_i = 1'b0;
        xadc_drdy_i = 1'b1; xadc_do_i = 16'h1110;
        tick();
        xadc_drdy_i = 1'b0;
        read_check("overrun_set", 32'h058, 32'h0000_0009);
        read_check("res_ch1", 32'h104, 32'h0000_0111);
        bus_write(32'h058, 32'h2);
        read_check("flags_cleared", 32'h058, 32'h0000_0008);

        // Overrun event and clear in the same cycle: set wins
        xadc_eoc_i = 1'b1; xadc_channel_i = 5'd7;
        tick();
        sys_addr = 32'h058; sys_wdata = 32'h2; sys_wen = 1'b1;
        tick();
        sys_wen = 1'b0; xadc_eoc_i = 1'b0;
        xadc_drdy_i = 1'b1; xadc_do_i = 16'h7770;
        tick();
        xadc_drdy_i = 1'b0;
        read_check("set_wins_clear", 32'h058, 32'h0000_0009);
        bus_write(32'h058, 32'h2);

        // Timeout
        xadc_eoc_i = 1'b1; xadc_channel_i = 5'd2;
        tick();
        xadc_eoc_i = 1'b0;
        repeat (245) tick();
        read_check("no_timeout_early", 32'h058, 32'h0000_0008);
        repeat (15) tick();
        read_check("timeout_set", 32'h058, 32'h0000_000A);
        xadc_drdy_i = 1'b1; xadc_do_i = 16'hFFF0;
        tick();
        xadc_drdy_i = 1'b0;
        read_check("late_drdy_ignored", 32'h108, 32'h0);
        conv(5'd5, 16'h5550);
        read_check("res_after_timeout", 32'h114, 32'h0000_0555);
        bus_write(32'h058, 32'h2);

        // FIFO fill past capacity
        bus_write(32'h05C, 32'd16);
        fifo_ch_m = 5'd16;
        for (int i = 0; i < DEPTH + 1; i++) begin
            smp = 16'(((i * 37 + 5) & 12'hFFF) << 4) | 16'(i & 15);
            conv(5'd16, smp);
        end
        read_check("fifo_full_status", 32'h058, 32'h0040_0014);
        for (int i = 0; i < DEPTH; i++) fifo_read_check($sformatf("fifo_pop%0d", i));
        fifo_read_check("fifo_empty_read");
        read_check("fifo_drained_status", 32'h058, 32'h0000_000C);

        // Push and pop in the same cycle at count 5
        bus_write(32'h058, 32'h2);
        for (int i = 0; i < 5; i++) conv(5'd16, 16'((i + 1) * 16'h1110));
        read_check("fifo_count5", 32'h058, 32'h0005_0000);
        xadc_eoc_i = 1'b1; xadc_channel_i = 5'd16;
        tick();
        xadc_eoc_i = 1'b0;
        tick();
        xadc_drdy_i = 1'b1; xadc_do_i = 16'h9990;
        sys_addr = 32'h060; sys_ren = 1'b1;
        tick();
        xadc_drdy_i = 1'b0; sys_ren = 1'b0;
        check("pushpop_data", sys_rdata, exp_q.pop_front());
        exp_q.push_back({11'd0, 5'd16, 4'd0, 12'h999});
        read_check("pushpop_count", 32'h058, 32'h0005_0000);
        fifo_read_check("fifo_after_pushpop");

        // Flush with a simultaneous push: both discarded
        xadc_eoc_i = 1'b1; xadc_channel_i = 5'd16;
        tick();
        xadc_eoc_i = 1'b0;
        tick();
        xadc_drdy_i = 1'b1; xadc_do_i = 16'h4440;
        sys_addr = 32'h058; sys_wdata = 32'h4; sys_wen = 1'b1;
        tick();
        xadc_drdy_i = 1'b0; sys_wen = 1'b0;
        exp_q.delete();
        read_check("flush_status", 32'h058, 32'h0000_0008);
        fifo_read_check("flush_empty_read");

        // Reset in the middle of a DRP transaction
        xadc_eoc_i = 1'b1; xadc_channel_i = 5'd9;
        tick();
        xadc_eoc_i = 1'b0;
        rstn = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        fifo_ch_m = '0;
        xadc_drdy_i = 1'b1; xadc_do_i = 16'h7770;
        tick();
        xadc_drdy_i = 1'b0;
        check("rst_mid_den", xadc_den_o, 1'b0);
        read_check("rst_mid_result", 32'h124, 32'h0);
        read_check("rst_mid_trig_src", 32'h050, 32'h0001_0000);
        read_check("rst_mid_dac", 32'h004, 32'h0);
        conv(5'd9, 16'h2220);
        read_check("rst_mid_new_conv", 32'h124, 32'h0000_0222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
